// File: rtl/td_pkg.sv
// Shared constants, IEEE-754 field view and the TD clip helper for the TD error unit.
package td_pkg;

    localparam logic [31:0] FP_ZERO    = 32'h0000_0000;
    localparam logic [31:0] FP_ONE_POS = 32'h3F80_0000;
    localparam logic [31:0] FP_ONE_NEG = 32'hBF80_0000;
    localparam logic [31:0] FP_QNAN    = 32'h7FC0_0000;

    localparam int unsigned DEF_MUL_LAT = 7;
    localparam int unsigned DEF_ADD_LAT = 7;

    typedef struct packed {
        logic        sign;
        logic [7:0]  expo;
        logic [22:0] man;
    } fp32_t;

    // Saturate to +/-1.0 for |x| >= 1.0 (infinities included); NaN passes through.
    function automatic logic [31:0] fp_clip(input logic [31:0] x);
        fp32_t f;
        f = x;
        if (f.expo == 8'hFF && f.man != 23'd0) begin
            return x;
        end
        if (f.expo >= 8'd127) begin
            return f.sign ? FP_ONE_NEG : FP_ONE_POS;
        end
        return x;
    endfunction

endpackage

// File: rtl/adder_floating_point32.sv
// Single-precision adder, round-to-nearest-even, denormals flushed, fixed LAT-cycle latency.
module adder_floating_point32
    import td_pkg::*;
#(
    parameter int unsigned LAT = DEF_ADD_LAT
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        valid_i,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    output logic        valid_o,
    output logic [31:0] result_o
);

    fp32_t       a, b, big, sml;
    logic        nan_a, nan_b, inf_a, inf_b;
    logic [7:0]  d;
    logic [50:0] big_m, sml_m, sum, norm;
    logic [5:0]  lz;
    logic [22:0] man;
    logic        guard, sticky, inc;
    logic [23:0] man_rnd;
    logic [9:0]  exp_t;
    logic [31:0] res;

    logic        vld_q  [LAT];
    logic [31:0] data_q [LAT];

    always_comb begin
        a     = a_i;
        b     = b_i;
        nan_a = (a.expo == 8'hFF) && (a.man != 23'd0);
        nan_b = (b.expo == 8'hFF) && (b.man != 23'd0);
        inf_a = (a.expo == 8'hFF) && (a.man == 23'd0);
        inf_b = (b.expo == 8'hFF) && (b.man == 23'd0);
        if ({a.expo, a.man} >= {b.expo, b.man}) begin
            big = a;
            sml = b;
        end else begin
            big = b;
            sml = a;
        end
        d     = big.expo - sml.expo;
        // 26 guard bits keep every alignment shift up to 26 exact.
        big_m = {2'b01, big.man, 26'd0};
        sml_m = {2'b01, sml.man, 26'd0} >> d;
        sum   = (big.sign == sml.sign) ? big_m + sml_m : big_m - sml_m;
        lz    = 6'd50;
        for (int i = 0; i < 51; i++) begin
            if (sum[i]) begin
                lz = 6'(50 - i);
            end
        end
        norm    = sum << lz;
        man     = norm[49:27];
        guard   = norm[26];
        sticky  = |norm[25:0];
        inc     = guard & (sticky | man[0]);
        man_rnd = {1'b0, man} + {23'd0, inc};
        exp_t   = {2'b00, big.expo} + 10'd1 + {9'd0, man_rnd[23]};

        if (nan_a || nan_b || (inf_a && inf_b && a.sign != b.sign)) begin
            res = FP_QNAN;
        end else if (inf_a) begin
            res = a_i;
        end else if (inf_b) begin
            res = b_i;
        end else if (a.expo == 8'h00 && b.expo == 8'h00) begin
            res = {a.sign & b.sign, 31'd0};
        end else if (a.expo == 8'h00) begin
            res = b_i;
        end else if (b.expo == 8'h00) begin
            res = a_i;
        end else if (d > 8'd26) begin
            // Smaller operand is below a quarter ulp: nearest result is the larger one.
            res = big;
        end else if (sum == '0) begin
            res = FP_ZERO;
        end else if (exp_t >= 10'd255 + {4'd0, lz}) begin
            res = {big.sign, 8'hFF, 23'd0};
        end else if (exp_t <= {4'd0, lz}) begin
            res = {big.sign, 31'd0};
        end else begin
            res = {big.sign, 8'(exp_t - {4'd0, lz}), man_rnd[22:0]};
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < LAT; i++) begin
                vld_q[i]  <= 1'b0;
                data_q[i] <= '0;
            end
        end else begin
            vld_q[0]  <= valid_i;
            data_q[0] <= res;
            for (int i = 1; i < LAT; i++) begin
                vld_q[i]  <= vld_q[i-1];
                data_q[i] <= data_q[i-1];
            end
        end
    end

    assign valid_o  = vld_q[LAT-1];
    assign result_o = data_q[LAT-1];

endmodule

// File: rtl/multiplier_floating_point32.sv
// Single-precision multiplier, round-to-nearest-even, denormals flushed, fixed LAT-cycle latency.
module multiplier_floating_point32
    import td_pkg::*;
#(
    parameter int unsigned LAT = DEF_MUL_LAT
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        valid_i,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    output logic        valid_o,
    output logic [31:0] result_o
);

    fp32_t       a, b;
    logic        sign, nan_any, inf_any, zero_any;
    logic [47:0] prod;
    logic [22:0] man;
    logic        guard, sticky, inc;
    logic [23:0] man_rnd;
    logic [9:0]  exp_sum;
    logic [31:0] res;

    logic        vld_q  [LAT];
    logic [31:0] data_q [LAT];

    always_comb begin
        a        = a_i;
        b        = b_i;
        sign     = a.sign ^ b.sign;
        nan_any  = (a.expo == 8'hFF && a.man != 23'd0) || (b.expo == 8'hFF && b.man != 23'd0) ||
                   (a.expo == 8'hFF && b.expo == 8'h00) || (b.expo == 8'hFF && a.expo == 8'h00);
        inf_any  = (a.expo == 8'hFF) || (b.expo == 8'hFF);
        zero_any = (a.expo == 8'h00) || (b.expo == 8'h00);
        prod     = 48'({1'b1, a.man}) * 48'({1'b1, b.man});
        if (prod[47]) begin
            man    = prod[46:24];
            guard  = prod[23];
            sticky = |prod[22:0];
        end else begin
            man    = prod[45:23];
            guard  = prod[22];
            sticky = |prod[21:0];
        end
        inc     = guard & (sticky | man[0]);
        man_rnd = {1'b0, man} + {23'd0, inc};
        // Biased by an extra 127; underflow/overflow are judged against that offset.
        exp_sum = {2'b00, a.expo} + {2'b00, b.expo} + {9'd0, prod[47]} + {9'd0, man_rnd[23]};
        if (nan_any) begin
            res = FP_QNAN;
        end else if (inf_any) begin
            res = {sign, 8'hFF, 23'd0};
        end else if (zero_any || exp_sum <= 10'd127) begin
            res = {sign, 31'd0};
        end else if (exp_sum >= 10'd382) begin
            res = {sign, 8'hFF, 23'd0};
        end else begin
            res = {sign, 8'(exp_sum - 10'd127), man_rnd[22:0]};
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < LAT; i++) begin
                vld_q[i]  <= 1'b0;
                data_q[i] <= '0;
            end
        end else begin
            vld_q[0]  <= valid_i;
            data_q[0] <= res;
            for (int i = 1; i < LAT; i++) begin
                vld_q[i]  <= vld_q[i-1];
                data_q[i] <= data_q[i-1];
            end
        end
    end

    assign valid_o  = vld_q[LAT-1];
    assign result_o = data_q[LAT-1];

endmodule

// File: rtl/td_align_fifo.sv
// First-word-fall-through alignment FIFO with drop-on-full and zero-on-empty semantics.
module td_align_fifo #(
    parameter int unsigned Width = 32,
    parameter int unsigned Depth = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [Width-1:0] wdata_i,
    input  logic             pop_i,
    output logic [Width-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o,
    output logic             overflow_o,
    output logic             underflow_o
);

    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam logic [PtrW:0] FullCnt = Depth[PtrW:0];

    logic [Width-1:0] mem_q [Depth];
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PtrW:0]    count_q, count_d;
    logic             push_ok, pop_ok;

    always_comb begin
        empty_o     = (count_q == '0);
        full_o      = (count_q == FullCnt);
        pop_ok      = pop_i & ~empty_o;
        // A pop in the same cycle frees the slot the push lands in.
        push_ok     = push_i & (~full_o | pop_ok);
        overflow_o  = push_i & ~push_ok;
        underflow_o = pop_i & empty_o;
        rdata_o     = empty_o ? '0 : mem_q[rd_ptr_q];
        wr_ptr_d    = push_ok ? wr_ptr_q + PtrW'(1) : wr_ptr_q;
        rd_ptr_d    = pop_ok ? rd_ptr_q + PtrW'(1) : rd_ptr_q;
        count_d     = count_q + {{PtrW{1'b0}}, push_ok} - {{PtrW{1'b0}}, pop_ok};
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/td_error_unit.sv
// Pipelined TD error: (reward + gamma*Qmax) - Q, with reward/Q/tag held in alignment FIFOs.
module td_error_unit
    import td_pkg::*;
#(
    parameter int unsigned TAG_W      = 8,
    parameter int unsigned FIFO_DEPTH = 32,
    parameter int unsigned MUL_LAT    = DEF_MUL_LAT,
    parameter int unsigned ADD_LAT    = DEF_ADD_LAT,
    parameter bit          CLIP_EN    = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid_in,
    input  logic [31:0]      gamma,
    input  logic [31:0]      Qmax,
    input  logic [31:0]      reward,
    input  logic [31:0]      Q,
    input  logic             done,
    input  logic [TAG_W-1:0] tag_in,
    output logic             valid_out,
    output logic [31:0]      TD,
    output logic [TAG_W-1:0] tag_out,
    output logic             ovf_err
);

    localparam int unsigned QW = 32 + TAG_W;

    logic             rst_n;
    logic [31:0]      mul_b, mul_res, add1_res, add2_res, r_head, q_head, q_neg, td_d;
    logic             mul_valid, add1_valid, add2_valid;
    logic [TAG_W-1:0] q_tag;
    logic [QW-1:0]    q_rdata;
    logic             r_full, r_empty, r_ovf, r_unf;
    logic             q_full, q_empty, q_ovf, q_unf;

    logic [TAG_W-1:0] tag_pipe_q [ADD_LAT];
    logic             valid_out_q;
    logic [31:0]      td_q;
    logic [TAG_W-1:0] tag_out_q;
    logic             ovf_q;

    assign rst_n = ~rst;
    // Terminal samples drop the bootstrap term by multiplying with +0.0.
    assign mul_b = done ? FP_ZERO : Qmax;

    multiplier_floating_point32 #(.LAT(MUL_LAT)) u_mul (
        .clk_i    (clk),
        .rst_ni   (rst_n),
        .valid_i  (valid_in),
        .a_i      (gamma),
        .b_i      (mul_b),
        .valid_o  (mul_valid),
        .result_o (mul_res)
    );

    td_align_fifo #(.Width(32), .Depth(FIFO_DEPTH)) u_fifo_r (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .push_i      (valid_in),
        .wdata_i     (reward),
        .pop_i       (mul_valid),
        .rdata_o     (r_head),
        .full_o      (r_full),
        .empty_o     (r_empty),
        .overflow_o  (r_ovf),
        .underflow_o (r_unf)
    );

    adder_floating_point32 #(.LAT(ADD_LAT)) u_add1 (
        .clk_i    (clk),
        .rst_ni   (rst_n),
        .valid_i  (mul_valid),
        .a_i      (r_head),
        .b_i      (mul_res),
        .valid_o  (add1_valid),
        .result_o (add1_res)
    );

    td_align_fifo #(.Width(QW), .Depth(FIFO_DEPTH)) u_fifo_q (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .push_i      (valid_in),
        .wdata_i     ({Q, tag_in}),
        .pop_i       (add1_valid),
        .rdata_o     (q_rdata),
        .full_o      (q_full),
        .empty_o     (q_empty),
        .overflow_o  (q_ovf),
        .underflow_o (q_unf)
    );

    assign q_head = q_rdata[QW-1:TAG_W];
    assign q_tag  = q_rdata[TAG_W-1:0];
    assign q_neg  = {~q_head[31], q_head[30:0]};

    adder_floating_point32 #(.LAT(ADD_LAT)) u_add2 (
        .clk_i    (clk),
        .rst_ni   (rst_n),
        .valid_i  (add1_valid),
        .a_i      (add1_res),
        .b_i      (q_neg),
        .valid_o  (add2_valid),
        .result_o (add2_res)
    );

    // Tag travels alongside the subtractor pipeline.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < ADD_LAT; i++) begin
                tag_pipe_q[i] <= '0;
            end
        end else begin
            tag_pipe_q[0] <= q_tag;
            for (int i = 1; i < ADD_LAT; i++) begin
                tag_pipe_q[i] <= tag_pipe_q[i-1];
            end
        end
    end

    always_comb begin
        td_d = CLIP_EN ? fp_clip(add2_res) : add2_res;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_out_q <= 1'b0;
            td_q        <= '0;
            tag_out_q   <= '0;
            ovf_q       <= 1'b0;
        end else begin
            valid_out_q <= add2_valid;
            if (add2_valid) begin
                td_q      <= td_d;
                tag_out_q <= tag_pipe_q[ADD_LAT-1];
            end
            ovf_q <= ovf_q | r_ovf | r_unf | q_ovf | q_unf;
        end
    end

    assign valid_out = valid_out_q;
    assign TD        = td_q;
    assign tag_out   = tag_out_q;
    assign ovf_err   = ovf_q;

endmodule

// File: tb/tb_td_error_unit.sv
// Directed bench: default, clipping and shallow-FIFO instances driven from one stimulus set.
module tb_td_error_unit;

    localparam int TW  = 8;
    localparam int LAT = 22;

    logic          clk = 1'b0;
    logic          rst;
    logic          valid_in, done;
    logic [31:0]   gamma, qmax, reward, q;
    logic [TW-1:0] tag_in;
    logic          v0, v1, v2, o0, o1, o2;
    logic [31:0]   td0, td1, td2;
    logic [TW-1:0] t0, t1, t2;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    td_error_unit #(.TAG_W(TW)) dut (
        .clk(clk), .rst(rst), .valid_in(valid_in), .gamma(gamma), .Qmax(qmax), .reward(reward),
        .Q(q), .done(done), .tag_in(tag_in), .valid_out(v0), .TD(td0), .tag_out(t0), .ovf_err(o0)
    );

    td_error_unit #(.TAG_W(TW), .CLIP_EN(1'b1)) dut_clip (
        .clk(clk), .rst(rst), .valid_in(valid_in), .gamma(gamma), .Qmax(qmax), .reward(reward),
        .Q(q), .done(done), .tag_in(tag_in), .valid_out(v1), .TD(td1), .tag_out(t1), .ovf_err(o1)
    );

    td_error_unit #(.TAG_W(TW), .FIFO_DEPTH(4)) dut_small (
        .clk(clk), .rst(rst), .valid_in(valid_in), .gamma(gamma), .Qmax(qmax), .reward(reward),
        .Q(q), .done(done), .tag_in(tag_in), .valid_out(v2), .TD(td2), .tag_out(t2), .ovf_err(o2)
    );

    // Encodes the value k/2 (k < 2^24) as a single-precision float.
    function automatic logic [31:0] fp_half(input int unsigned k);
        int          p;
        logic [31:0] kk, m;
        p  = 0;
        kk = k;
        if (k == 0) return 32'h0;
        for (int i = 0; i < 32; i++) if (kk[i]) p = i;
        m = kk << (23 - p);
        return {1'b0, 8'(126 + p), m[22:0]};
    endfunction

    task automatic drive_and_wait(input logic [31:0] g, qm, r, qq, input logic d,
                                  input logic [TW-1:0] tg, output int lat);
        @(negedge clk);
        gamma = g; qmax = qm; reward = r; q = qq; done = d; tag_in = tg; valid_in = 1'b1;
        @(negedge clk);
        valid_in = 1'b0;
        lat = 1;
        while (!v0 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_tests++;
        if (v0 !== 1'b0 || v1 !== 1'b0 || v2 !== 1'b0) begin
            n_fail++; $display("FAIL reset_valid: got %b%b%b want 000", v0, v1, v2);
        end
        n_tests++;
        if (td0 !== 32'h0 || t0 !== '0) begin
            n_fail++; $display("FAIL reset_td_tag: got %h/%h want 0/0", td0, t0);
        end
        n_tests++;
        if (o0 !== 1'b0 || o2 !== 1'b0) begin
            n_fail++; $display("FAIL reset_ovf: got %b/%b want 0/0", o0, o2);
        end
        rst = 1'b0;
    endtask

    task automatic test_basic();
        int lat;
        drive_and_wait(32'h3F000000, 32'h40000000, 32'h3F800000, 32'h3F000000, 1'b0, 8'h11, lat);
        n_tests++;
        if (lat != LAT) begin n_fail++; $display("FAIL basic_latency: got %0d want %0d", lat, LAT); end
        n_tests++;
        if (td0 !== 32'h3FC00000) begin n_fail++; $display("FAIL basic_td: got %h want 3fc00000", td0); end
        n_tests++;
        if (t0 !== 8'h11) begin n_fail++; $display("FAIL basic_tag: got %h want 11", t0); end
        n_tests++;
        if (v1 !== 1'b1 || td1 !== 32'h3F800000) begin
            n_fail++; $display("FAIL basic_clip_td: got v=%b %h want v=1 3f800000", v1, td1);
        end
        @(negedge clk);
        n_tests++;
        if (v0 !== 1'b0) begin n_fail++; $display("FAIL basic_pulse: got valid=%b want 0", v0); end
        n_tests++;
        if (td0 !== 32'h3FC00000 || t0 !== 8'h11) begin
            n_fail++; $display("FAIL basic_hold: got %h/%h want 3fc00000/11", td0, t0);
        end
    endtask

    task automatic test_clip_neg();
        int lat;
        drive_and_wait(32'h3F000000, 32'h00000000, 32'hC0400000, 32'h00000000, 1'b0, 8'h22, lat);
        n_tests++;
        if (lat != LAT) begin n_fail++; $display("FAIL clip_latency: got %0d want %0d", lat, LAT); end
        n_tests++;
        if (td0 !== 32'hC0400000) begin n_fail++; $display("FAIL clip_raw_td: got %h want c0400000", td0); end
        n_tests++;
        if (td1 !== 32'hBF800000 || t1 !== 8'h22) begin
            n_fail++; $display("FAIL clip_neg_td: got %h/%h want bf800000/22", td1, t1);
        end
    endtask

    task automatic test_done();
        int lat;
        drive_and_wait(32'h3F000000, 32'h7F800000, 32'h3F800000, 32'h3F000000, 1'b1, 8'h33, lat);
        n_tests++;
        if (lat != LAT) begin n_fail++; $display("FAIL done_latency: got %0d want %0d", lat, LAT); end
        n_tests++;
        if (td0 !== 32'h3F000000 || t0 !== 8'h33) begin
            n_fail++; $display("FAIL done_td: got %h/%h want 3f000000/33", td0, t0);
        end
        n_tests++;
        if (td1 !== 32'h3F000000) begin n_fail++; $display("FAIL done_clip_td: got %h want 3f000000", td1); end
        done = 1'b0;
    endtask

    task automatic test_back_to_back();
        int out_idx;
        out_idx = 0;
        for (int cyc = 0; cyc < 70; cyc++) begin
            @(negedge clk);
            if (v0) begin
                n_tests++;
                if (out_idx >= 40 || cyc != out_idx + LAT) begin
                    n_fail++; $display("FAIL b2b_order: output %0d at cycle %0d want cycle %0d", out_idx, cyc, out_idx + LAT);
                end else if (td0 !== fp_half(2 * out_idx + 1) || t0 !== TW'(out_idx)) begin
                    n_fail++; $display("FAIL b2b_data[%0d]: got %h/%h want %h/%h", out_idx, td0, t0, fp_half(2 * out_idx + 1), TW'(out_idx));
                end
                out_idx++;
            end
            if (cyc < 40) begin
                valid_in = 1'b1; gamma = 32'h3F000000; qmax = 32'h40000000; q = 32'h3F000000;
                reward = fp_half(2 * cyc); done = 1'b0; tag_in = TW'(cyc);
            end else begin
                valid_in = 1'b0;
            end
        end
        n_tests++;
        if (out_idx != 40) begin n_fail++; $display("FAIL b2b_count: got %0d outputs want 40", out_idx); end
        n_tests++;
        if (o0 !== 1'b0) begin n_fail++; $display("FAIL b2b_ovf: got %b want 0", o0); end
    endtask

    task automatic test_overflow();
        n_tests++;
        if (o2 !== 1'b1) begin n_fail++; $display("FAIL small_ovf_set: got %b want 1", o2); end
        repeat (5) @(negedge clk);
        n_tests++;
        if (o2 !== 1'b1) begin n_fail++; $display("FAIL small_ovf_sticky: got %b want 1", o2); end
    endtask

    task automatic test_reset_mid_burst();
        int n_out, first;
        for (int cyc = 0; cyc < 10; cyc++) begin
            @(negedge clk);
            valid_in = 1'b1; gamma = 32'h3F000000; qmax = 32'h40000000; q = 32'h3F000000;
            reward = fp_half(2 * cyc); done = 1'b0; tag_in = TW'(cyc);
        end
        @(negedge clk);
        rst = 1'b1; valid_in = 1'b0;
        #1;
        n_tests++;
        if (v0 !== 1'b0 || td0 !== 32'h0 || t0 !== '0) begin
            n_fail++; $display("FAIL midrst_outputs: got v=%b %h/%h want 0 0/0", v0, td0, t0);
        end
        n_tests++;
        if (o2 !== 1'b0) begin n_fail++; $display("FAIL midrst_ovf_clear: got %b want 0", o2); end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        valid_in = 1'b1; reward = fp_half(14); tag_in = 8'hA5;
        n_out = 0;
        first = -1;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            @(negedge clk);
            valid_in = 1'b0;
            if (v0) begin
                n_out++;
                if (first < 0) first = cyc;
            end
        end
        n_tests++;
        if (n_out != 1 || first != LAT) begin
            n_fail++; $display("FAIL midrst_stale: got %0d outputs first at %0d want 1 at %0d", n_out, first, LAT);
        end
        n_tests++;
        if (td0 !== fp_half(15) || t0 !== 8'hA5) begin
            n_fail++; $display("FAIL midrst_td: got %h/%h want %h/a5", td0, t0, fp_half(15));
        end
    endtask

    initial begin
        rst = 1'b1; valid_in = 1'b0; done = 1'b0;
        gamma = '0; qmax = '0; reward = '0; q = '0; tag_in = '0;
        test_reset();
        test_basic();
        test_clip_neg();
        test_done();
        test_back_to_back();
        test_overflow();
        test_reset_mid_burst();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
